// File: rtl/lcd_text_pkg.sv
// Shared types and constants for the LCD text-mode pixel engine.
`timescale 1ns/1ps
package lcd_text_pkg;

    localparam int unsigned CHAR_W = 8;
    localparam int unsigned CHAR_H = 16;
    localparam int unsigned GXW    = $clog2(CHAR_W);
    localparam int unsigned GYW    = $clog2(CHAR_H);
    localparam logic [7:0]  CHAR_SPACE = 8'h20;

    typedef logic [23:0] rgb_t;

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    // One text-buffer cell: inverse attribute plus 7-bit ASCII code.
    typedef struct packed {
        logic       inv;
        logic [6:0] code;
    } cell_t;

endpackage

// File: rtl/lcd_text_engine_if.sv
// Character write port (valid/ready) into the text buffer.
`timescale 1ns/1ps
interface lcd_text_engine_if #(
    parameter int unsigned XW = 7,
    parameter int unsigned YW = 5
);
    import lcd_text_pkg::*;

    logic          wr_valid;
    logic          wr_ready;
    logic [XW-1:0] wr_x;
    logic [YW-1:0] wr_y;
    cell_t         wr_char;

    modport master (output wr_valid, wr_x, wr_y, wr_char, input wr_ready);
    modport slave  (input wr_valid, wr_x, wr_y, wr_char, output wr_ready);

endinterface

// File: rtl/lcd_text_engine_font.sv
// 128-glyph 8x16 font ROM with registered row output (one PIX_EN stage).
`timescale 1ns/1ps
module char_font_rom
    import lcd_text_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [6:0]     code,
    input  logic [GYW-1:0] row,
    output logic [7:0]     row_bits
);

    logic [7:0] row_bits_c;

    // Only space and 'A' carry real artwork; other codes show a hollow box.
    always_comb begin
        row_bits_c = 8'h00;
        case (code)
            7'h20: row_bits_c = 8'h00;
            7'h41: begin
                case (row)
                    4'd2:  row_bits_c = 8'h10;
                    4'd3:  row_bits_c = 8'h38;
                    4'd4:  row_bits_c = 8'h6C;
                    4'd7:  row_bits_c = 8'hFE;
                    4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11: row_bits_c = 8'hC6;
                    default: row_bits_c = 8'h00;
                endcase
            end
            default: begin
                case (row)
                    4'd2, 4'd11: row_bits_c = 8'hFF;
                    4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10: row_bits_c = 8'h81;
                    default: row_bits_c = 8'h00;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  row_bits <= 8'h00;
        else if (en) row_bits <= row_bits_c;
    end

endmodule

// File: rtl/lcd_text_engine.sv
// Text-mode pixel generator: character buffer, clear FSM, blinking cursor, 2-stage RGB pipe.
`timescale 1ns/1ps
module lcd_text_engine
    import lcd_text_pkg::*;
#(
    parameter int unsigned TEXT_COLS    = 100,
    parameter int unsigned TEXT_ROWS    = 30,
    parameter rgb_t        FG_RGB       = 24'hFFFFFF,
    parameter rgb_t        BG_RGB       = 24'h000080,
    parameter int unsigned BLINK_FRAMES = 30,
    localparam int unsigned XW = $clog2(TEXT_COLS),
    localparam int unsigned YW = $clog2(TEXT_ROWS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pix_en,
    input  logic                frame_sof,
    input  logic                den,
    input  logic [9:0]          fila,
    input  logic [10:0]         columna,
    lcd_text_engine_if.slave    wr,
    input  logic                clr_req,
    input  logic                cur_en,
    input  logic [XW-1:0]       cur_x,
    input  logic [YW-1:0]       cur_y,
    output logic                busy,
    output logic                out_den,
    output logic [7:0]          r,
    output logic [7:0]          g,
    output logic [7:0]          b
);

    localparam int unsigned N  = TEXT_COLS * TEXT_ROWS;
    localparam int unsigned AW = $clog2(N);
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

    state_t        state, state_nxt;
    logic [AW-1:0] clr_addr, clr_addr_nxt;

    // Clear/idle state register; busy and wr_ready registered from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_CLEAR;
            clr_addr    <= '0;
            busy        <= 1'b1;
            wr.wr_ready <= 1'b0;
        end else begin
            state       <= state_nxt;
            clr_addr    <= clr_addr_nxt;
            busy        <= (state_nxt == ST_CLEAR);
            wr.wr_ready <= (state_nxt == ST_IDLE);
        end
    end

    always_comb begin
        state_nxt    = state;
        clr_addr_nxt = clr_addr;
        case (state)
            ST_CLEAR: begin
                if (clr_addr == LAST_ADDR) begin
                    state_nxt    = ST_IDLE;
                    clr_addr_nxt = '0;
                end else begin
                    clr_addr_nxt = clr_addr + AW'(1);
                end
            end
            ST_IDLE: begin
                if (clr_req) begin
                    state_nxt    = ST_CLEAR;
                    clr_addr_nxt = '0;
                end
            end
            default: state_nxt = ST_CLEAR;
        endcase
    end

    // Write port: out-of-range coordinates complete the handshake but never reach the RAM.
    logic          wr_fire, wr_in_range, ram_we;
    logic [AW-1:0] wr_addr, ram_wa;
    cell_t         ram_wd;

    assign wr_fire     = wr.wr_valid && wr.wr_ready;
    assign wr_in_range = ({1'b0, wr.wr_x} < (XW+1)'(TEXT_COLS)) &&
                         ({1'b0, wr.wr_y} < (YW+1)'(TEXT_ROWS));
    assign wr_addr     = AW'(wr.wr_y) * AW'(TEXT_COLS) + AW'(wr.wr_x);
    assign ram_we      = (state == ST_CLEAR) || (wr_fire && wr_in_range);
    assign ram_wa      = (state == ST_CLEAR) ? clr_addr : wr_addr;
    assign ram_wd      = (state == ST_CLEAR) ? cell_t'(CHAR_SPACE) : wr.wr_char;

    // Simple dual-port text RAM, read-first on address collision.
    cell_t         ram [N];
    cell_t         ram_q;
    logic [AW-1:0] rd_addr;

    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_wa] <= ram_wd;
    end

    always_ff @(posedge clk) begin
        if (pix_en) ram_q <= ram[rd_addr];
    end

    // Cursor blink: phase toggles every BLINK_FRAMES start-of-frame pulses.
    logic [FW-1:0] frame_cnt;
    logic          blink_on;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (frame_sof) begin
            if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                frame_cnt <= frame_cnt + FW'(1);
            end
        end
    end

    // Stage 1: cell address, glyph coordinates, area and cursor flags.
    logic [10:0]    cell_col;
    logic [9:0]     cell_row;
    logic [GXW-1:0] gx_c, gx_s1, gx_s2;
    logic [GYW-1:0] gy_c, gy_s1;
    logic           in_area_c, cur_hit_c;
    logic           den_s1, area_s1, cur_s1;
    logic           den_s2, area_s2, cur_s2, inv_s2;

    assign cell_col  = columna / 11'(CHAR_W);
    assign cell_row  = fila / 10'(CHAR_H);
    assign gx_c      = GXW'(columna % 11'(CHAR_W));
    assign gy_c      = GYW'(fila % 10'(CHAR_H));
    assign in_area_c = (cell_col < 11'(TEXT_COLS)) && (cell_row < 10'(TEXT_ROWS));
    assign rd_addr   = in_area_c ? (AW'(cell_row) * AW'(TEXT_COLS) + AW'(cell_col)) : '0;
    assign cur_hit_c = cur_en && blink_on && (cell_col == 11'(cur_x)) &&
                       (cell_row == 10'(cur_y)) && (gy_c >= GYW'(CHAR_H - 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gx_s1   <= '0;
            gy_s1   <= '0;
            den_s1  <= 1'b0;
            area_s1 <= 1'b0;
            cur_s1  <= 1'b0;
        end else if (pix_en) begin
            gx_s1   <= gx_c;
            gy_s1   <= gy_c;
            den_s1  <= den;
            area_s1 <= in_area_c;
            cur_s1  <= cur_hit_c;
        end
    end

    // Stage 2: font row lookup runs in parallel with the side-band registers.
    logic [7:0] font_bits;

    char_font_rom u_font (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (pix_en),
        .code     (ram_q.code),
        .row      (gy_s1),
        .row_bits (font_bits)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gx_s2   <= '0;
            den_s2  <= 1'b0;
            area_s2 <= 1'b0;
            cur_s2  <= 1'b0;
            inv_s2  <= 1'b0;
        end else if (pix_en) begin
            gx_s2   <= gx_s1;
            den_s2  <= den_s1;
            area_s2 <= area_s1;
            cur_s2  <= cur_s1;
            inv_s2  <= ram_q.inv;
        end
    end

    // Colour mux sits on stage-2 registers so RGB lands exactly two PIX_EN after input.
    rgb_t pix_rgb;
    logic lit;

    always_comb begin
        pix_rgb = '0;
        lit     = cur_s2 | font_bits[GXW'(CHAR_W - 1) - gx_s2];
        if (den_s2) begin
            if (!area_s2)          pix_rgb = BG_RGB;
            else if (lit ^ inv_s2) pix_rgb = FG_RGB;
            else                   pix_rgb = BG_RGB;
        end
    end

    assign {r, g, b} = pix_rgb;
    assign out_den   = den_s2;

endmodule
